// File: rtl/bus_wr_stream_master.sv
// Write master: turns a valid/ready word stream plus a (start address, word count)
// descriptor into bus write bursts of at most MAX_BURST beats that never cross a
// MAX_BURST-word boundary.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready. A valid
// source holds its payload stable until that edge and never waits on ready to assert valid.
module bus_wr_stream_master #(
    parameter int MAX_BURST = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [27:0] start_addr,
    input  logic [23:0] total_words,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [27:0] BUS_WR_ADDR,
    output logic [7:0]  BUS_WR_LEN,
    output logic        BUS_WR_ADDR_VALID,
    input  logic        BUS_WR_ADDR_READY,
    output logic [31:0] BUS_WR_DATA,
    output logic [3:0]  BUS_WR_STRB,
    output logic        BUS_WR_DATA_VALID,
    input  logic        BUS_WR_DATA_READY,
    output logic        BUS_WR_DATA_LAST,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam int OFF_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t      state;
    logic [27:0] cur_addr;
    logic [23:0] remaining;
    logic [7:0]  beat_cnt;
    logic        in_data;
    logic        beat_hs;

    // Burst length-1: the smaller of the words left and the room up to the next boundary.
    function automatic logic [7:0] burst_len(input logic [27:0] addr, input logic [23:0] rem);
        logic [8:0]  room;
        logic [23:0] beats;
        room  = 9'(MAX_BURST) - 9'(addr[OFF_W-1:0]);
        beats = (rem < 24'(room)) ? rem : 24'(room);
        return 8'(beats - 24'd1);
    endfunction

    assign in_data           = (state == DATA);
    assign s_ready           = in_data & BUS_WR_DATA_READY;
    assign BUS_WR_DATA_VALID = in_data & s_valid;
    assign BUS_WR_DATA       = s_data;
    assign BUS_WR_DATA_LAST  = in_data && (beat_cnt == BUS_WR_LEN);
    assign BUS_WR_STRB       = 4'hF;
    assign beat_hs           = BUS_WR_DATA_VALID & BUS_WR_DATA_READY;
    assign dbg_state         = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cur_addr          <= '0;
            remaining         <= '0;
            beat_cnt          <= '0;
            BUS_WR_ADDR       <= '0;
            BUS_WR_LEN        <= '0;
            BUS_WR_ADDR_VALID <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= start_addr;
                        remaining <= total_words;
                        if (total_words == 24'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state             <= ADDR;
                            busy              <= 1'b1;
                            BUS_WR_ADDR_VALID <= 1'b1;
                            BUS_WR_ADDR       <= start_addr;
                            BUS_WR_LEN        <= burst_len(start_addr, total_words);
                        end
                    end
                end
                ADDR: begin
                    // Bookkeeping advances at the address handshake, so the next burst is ready at LAST.
                    if (BUS_WR_ADDR_READY) begin
                        BUS_WR_ADDR_VALID <= 1'b0;
                        beat_cnt          <= '0;
                        cur_addr          <= cur_addr + 28'(BUS_WR_LEN) + 28'd1;
                        remaining         <= remaining - 24'(BUS_WR_LEN) - 24'd1;
                        state             <= DATA;
                    end
                end
                DATA: begin
                    if (beat_hs) begin
                        if (BUS_WR_DATA_LAST) begin
                            if (remaining != 24'd0) begin
                                state             <= ADDR;
                                BUS_WR_ADDR_VALID <= 1'b1;
                                BUS_WR_ADDR       <= cur_addr;
                                BUS_WR_LEN        <= burst_len(cur_addr, remaining);
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
